// File: rtl/conv_loop_sequencer.sv
// conv_loop_sequencer: walks the six nested loops of a 2-D convolution, issuing one tap per cycle
// with signed input coordinates, a bounds-qualified MAC enable and accumulator clear/save strobes.
module conv_loop_sequencer #(
  parameter int W       = 8,
  parameter int IMG_H   = 32,
  parameter int IMG_W   = 32,
  parameter int OUT_H   = 32,
  parameter int OUT_W   = 32,
  parameter int KER_H   = 5,
  parameter int KER_W   = 5,
  parameter int IN_CH   = 3,
  parameter int OUT_CH  = 32,
  parameter int STRIDE  = 1,
  parameter int PADDING = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  output logic                busy,
  output logic                done,
  output logic [W-1:0]        och,
  output logic [W-1:0]        oy,
  output logic [W-1:0]        ox,
  output logic [W-1:0]        ky,
  output logic [W-1:0]        kx,
  output logic [W-1:0]        ich,
  output logic signed [W:0]   in_row,
  output logic signed [W:0]   in_col,
  output logic                tap_valid,
  output logic                mac_en,
  output logic                acc_clr,
  output logic                acc_save
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [W-1:0] OCH_M = W'(OUT_CH - 1);
  localparam logic [W-1:0] OY_M  = W'(OUT_H - 1);
  localparam logic [W-1:0] OX_M  = W'(OUT_W - 1);
  localparam logic [W-1:0] KY_M  = W'(KER_H - 1);
  localparam logic [W-1:0] KX_M  = W'(KER_W - 1);
  localparam logic [W-1:0] ICH_M = W'(IN_CH - 1);
  localparam logic signed [W+1:0] STR = (W+2)'(STRIDE);
  localparam logic signed [W+1:0] PAD = (W+2)'(PADDING);
  localparam logic signed [W+1:0] IH  = (W+2)'(IMG_H);
  localparam logic signed [W+1:0] IW  = (W+2)'(IMG_W);
  state_t state_q, state_d;
  logic [W-1:0] och_q, och_d, oy_q, oy_d, ox_q, ox_d, ky_q, ky_d, kx_q, kx_d, ich_q, ich_d;
  logic ich_l, kx_l, ky_l, ox_l, oy_l, och_l, last;
  logic signed [W+1:0] row_full, col_full;
  function automatic logic [W-1:0] step(input logic [W-1:0] v, input logic wrap, input logic en);
    return en ? (wrap ? '0 : v + W'(1)) : v;
  endfunction
  always_comb begin
    tap_valid = (state_q == RUN) & ~stall;
    ich_l = ich_q == ICH_M;
    kx_l  = kx_q == KX_M;
    ky_l  = ky_q == KY_M;
    ox_l  = ox_q == OX_M;
    oy_l  = oy_q == OY_M;
    och_l = och_q == OCH_M;
    last  = ich_l & kx_l & ky_l & ox_l & oy_l & och_l;
    ich_d = step(ich_q, ich_l, tap_valid);
    kx_d  = step(kx_q, kx_l, tap_valid & ich_l);
    ky_d  = step(ky_q, ky_l, tap_valid & ich_l & kx_l);
    ox_d  = step(ox_q, ox_l, tap_valid & ich_l & kx_l & ky_l);
    oy_d  = step(oy_q, oy_l, tap_valid & ich_l & kx_l & ky_l & ox_l);
    och_d = step(och_q, och_l, tap_valid & ich_l & kx_l & ky_l & ox_l & oy_l);
    state_d = state_q == IDLE ? (start ? RUN : IDLE) :
              state_q == RUN  ? (tap_valid & last ? DONE : RUN) : IDLE;
    row_full = STR * $signed({2'b00, oy_q}) + $signed({2'b00, ky_q}) - PAD;
    col_full = STR * $signed({2'b00, ox_q}) + $signed({2'b00, kx_q}) - PAD;
    mac_en   = tap_valid & ~row_full[W+1] & (row_full < IH) & ~col_full[W+1] & (col_full < IW);
    acc_clr  = tap_valid & (ky_q == '0) & (kx_q == '0) & (ich_q == '0);
    acc_save = tap_valid & ky_l & kx_l & ich_l;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      och_q <= '0;
      oy_q  <= '0;
      ox_q  <= '0;
      ky_q  <= '0;
      kx_q  <= '0;
      ich_q <= '0;
    end else begin
      state_q <= state_d;
      och_q <= och_d;
      oy_q  <= oy_d;
      ox_q  <= ox_d;
      ky_q  <= ky_d;
      kx_q  <= kx_d;
      ich_q <= ich_d;
    end
  end
  assign busy   = state_q == RUN;
  assign done   = state_q == DONE;
  assign och    = och_q;
  assign oy     = oy_q;
  assign ox     = ox_q;
  assign ky     = ky_q;
  assign kx     = kx_q;
  assign ich    = ich_q;
  assign in_row = row_full[W:0];
  assign in_col = col_full[W:0];
endmodule

// File: tb/tb_conv_loop_sequencer.sv
// tb_conv_loop_sequencer: directed scoreboard bench for conv_loop_sequencer across three configurations.
module tb_conv_loop_sequencer;
  typedef struct packed {
    logic [7:0] och, oy, ox, ky, kx, ich;
    logic signed [8:0] row, col;
    logic mac, clr, save;
  } tap_t;
  logic clk = 0;
  logic rst, stall;
  logic st [3];
  logic busy_o [3], done_o [3], tv_o [3], mac_o [3], clr_o [3], save_o [3];
  logic [7:0] och_o [3], oy_o [3], ox_o [3], ky_o [3], kx_o [3], ich_o [3];
  logic signed [8:0] row_o [3], col_o [3];
  tap_t q [$];
  int pass_n = 0, total_n = 0;
  int taps, macs, clrs, saves, dones, done_k, px0, px11;
  bit was_reset;
  always #5 clk = ~clk;

  conv_loop_sequencer #(.W(8), .IMG_H(4), .IMG_W(4), .OUT_H(4), .OUT_W(4), .KER_H(3), .KER_W(3),
    .IN_CH(2), .OUT_CH(2), .STRIDE(1), .PADDING(1)) u0 (
    .clk(clk), .reset(rst), .start(st[0]), .stall(stall), .busy(busy_o[0]), .done(done_o[0]),
    .och(och_o[0]), .oy(oy_o[0]), .ox(ox_o[0]), .ky(ky_o[0]), .kx(kx_o[0]), .ich(ich_o[0]),
    .in_row(row_o[0]), .in_col(col_o[0]), .tap_valid(tv_o[0]), .mac_en(mac_o[0]),
    .acc_clr(clr_o[0]), .acc_save(save_o[0]));
  conv_loop_sequencer #(.W(8), .IMG_H(5), .IMG_W(5), .OUT_H(2), .OUT_W(2), .KER_H(3), .KER_W(3),
    .IN_CH(1), .OUT_CH(1), .STRIDE(2), .PADDING(0)) u1 (
    .clk(clk), .reset(rst), .start(st[1]), .stall(1'b0), .busy(busy_o[1]), .done(done_o[1]),
    .och(och_o[1]), .oy(oy_o[1]), .ox(ox_o[1]), .ky(ky_o[1]), .kx(kx_o[1]), .ich(ich_o[1]),
    .in_row(row_o[1]), .in_col(col_o[1]), .tap_valid(tv_o[1]), .mac_en(mac_o[1]),
    .acc_clr(clr_o[1]), .acc_save(save_o[1]));
  conv_loop_sequencer #(.W(8), .IMG_H(4), .IMG_W(4), .OUT_H(4), .OUT_W(4), .KER_H(1), .KER_W(1),
    .IN_CH(1), .OUT_CH(2), .STRIDE(1), .PADDING(0)) u2 (
    .clk(clk), .reset(rst), .start(st[2]), .stall(1'b0), .busy(busy_o[2]), .done(done_o[2]),
    .och(och_o[2]), .oy(oy_o[2]), .ox(ox_o[2]), .ky(ky_o[2]), .kx(kx_o[2]), .ich(ich_o[2]),
    .in_row(row_o[2]), .in_col(col_o[2]), .tap_valid(tv_o[2]), .mac_en(mac_o[2]),
    .acc_clr(clr_o[2]), .acc_save(save_o[2]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total_n++;
    assert (got === exp) pass_n++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic tap_t obs_tap(input int d);
    return {och_o[d], oy_o[d], ox_o[d], ky_o[d], kx_o[d], ich_o[d], row_o[d], col_o[d],
            mac_o[d], clr_o[d], save_o[d]};
  endfunction

  // Reference model: the six loops written out literally, expected taps queued in issue order.
  task automatic push_run(input int oc, oh, ow, kh, kw, ic, s, p, ih, iw);
    tap_t t;
    int r, c;
    for (int a = 0; a < oc; a++)
      for (int b = 0; b < oh; b++)
        for (int e = 0; e < ow; e++)
          for (int f = 0; f < kh; f++)
            for (int g = 0; g < kw; g++)
              for (int h = 0; h < ic; h++) begin
                r = s * b + f - p;
                c = s * e + g - p;
                t.och = 8'(a); t.oy = 8'(b); t.ox = 8'(e); t.ky = 8'(f); t.kx = 8'(g); t.ich = 8'(h);
                t.row = 9'(r); t.col = 9'(c);
                t.mac = r >= 0 && r < ih && c >= 0 && c < iw;
                t.clr = f == 0 && g == 0 && h == 0;
                t.save = f == kh - 1 && g == kw - 1 && h == ic - 1;
                q.push_back(t);
              end
  endtask

  task automatic run(input int d, input int s_at, input int s_len, input int f_len, input int r_at);
    int ss, fs;
    tap_t o, e;
    taps = 0; macs = 0; clrs = 0; saves = 0; dones = 0; done_k = -1; px0 = 0; px11 = 0;
    ss = 0; fs = 0; was_reset = 0;
    @(negedge clk); st[d] = 1;
    @(negedge clk); st[d] = 0;
    for (int k = 1; k < 2000; k++) begin
      if (r_at >= 0 && taps == r_at) begin
        rst = 1;
        @(negedge clk); rst = 0; #1;
        chk("reset_idle", {busy_o[d], done_o[d], tv_o[d], och_o[d], oy_o[d], ox_o[d], ky_o[d], kx_o[d], ich_o[d]}, 0);
        was_reset = 1;
        q.delete();
        break;
      end
      stall = d == 0 && ((s_at >= 0 && taps == s_at && ss < s_len) || (f_len > 0 && q.size() == 1 && fs < f_len));
      #1;
      if (stall) begin
        if (taps == s_at) ss++; else fs++;
        o = obs_tap(d); e = q[0];
        o.mac = 0; o.clr = 0; o.save = 0; e.mac = 0; e.clr = 0; e.save = 0;
        chk("stall_hold", o, e);
        chk("stall_no_tap", tv_o[d], 0);
      end else if (tv_o[d]) begin
        if (q.size() == 0) chk("extra_tap", 1, 0);
        else chk("tap", obs_tap(d), q.pop_front());
        if (taps == 0 && d == 0) begin
          chk("first_row", int'(row_o[d]), -1);
          chk("first_col", int'(col_o[d]), -1);
          chk("first_mac", mac_o[d], 0);
        end
        taps++;
        macs += int'(mac_o[d]); clrs += int'(clr_o[d]); saves += int'(save_o[d]);
        if (mac_o[d] && och_o[d] == 0 && oy_o[d] == 0 && ox_o[d] == 0) px0++;
        if (mac_o[d] && och_o[d] == 0 && oy_o[d] == 1 && ox_o[d] == 1) px11++;
      end
      if (done_o[d]) begin dones++; done_k = k; end
      @(negedge clk);
      stall = 0;
      if (done_k >= 0) break;
    end
    stall = 0;
    if (!was_reset) begin
      #1;
      chk("idle_after_done", {busy_o[d], done_o[d], tv_o[d]}, 0);
      chk("queue_drained", q.size(), 0);
    end
  endtask

  initial begin
    rst = 1; stall = 0;
    foreach (st[i]) st[i] = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (10) begin
      @(negedge clk); #1;
      chk("idle", {busy_o[0], done_o[0], tv_o[0], mac_o[0], clr_o[0], save_o[0],
                   och_o[0], oy_o[0], ox_o[0], ky_o[0], kx_o[0], ich_o[0]}, 0);
    end
    push_run(2, 4, 4, 3, 3, 2, 1, 1, 4, 4);
    run(0, -1, 0, 0, -1);
    chk("full_done_cycle", done_k, 577);
    chk("full_taps", taps, 576);
    chk("full_clr", clrs, 32);
    chk("full_save", saves, 32);
    chk("full_mac", macs, 400);
    chk("pixel00_mac", px0, 8);
    chk("pixel11_mac", px11, 18);
    chk("full_done_pulses", dones, 1);
    push_run(2, 4, 4, 3, 3, 2, 1, 1, 4, 4);
    run(0, 100, 5, 3, -1);
    chk("stall_done_cycle", done_k, 585);
    chk("stall_taps", taps, 576);
    chk("stall_mac", macs, 400);
    push_run(2, 4, 4, 3, 3, 2, 1, 1, 4, 4);
    run(0, -1, 0, 0, 50);
    chk("reset_taps", taps, 50);
    repeat (5) begin
      @(negedge clk); #1;
      chk("reset_no_done", {busy_o[0], done_o[0]}, 0);
    end
    push_run(2, 4, 4, 3, 3, 2, 1, 1, 4, 4);
    run(0, -1, 0, 0, -1);
    chk("restart_done_cycle", done_k, 577);
    chk("restart_taps", taps, 576);
    push_run(1, 2, 2, 3, 3, 1, 2, 0, 5, 5);
    run(1, -1, 0, 0, -1);
    chk("stride_taps", taps, 36);
    chk("stride_mac", macs, 36);
    chk("stride_done_cycle", done_k, 37);
    push_run(2, 4, 4, 1, 1, 1, 1, 0, 4, 4);
    run(2, -1, 0, 0, -1);
    chk("k1_taps", taps, 32);
    chk("k1_clr", clrs, 32);
    chk("k1_save", saves, 32);
    chk("k1_done_cycle", done_k, 33);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
